// File: rtl/addend_collector_pkg.sv
// Shared types for the addend collector and AdderTree wrappers: the collector
// FSM state and the default-width signed addend word.
package addend_collector_pkg;

    localparam int ADDEND_WIDTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } collector_state_t;

    typedef logic signed [ADDEND_WIDTH-1:0] addend_t;

endpackage

// File: rtl/addend_collector.sv
// Deserialises a valid/ready stream of signed words into a LENGTH-entry frame
// for AdderTree, zero-padding short frames closed by in_flush.
module addend_collector
    import addend_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 42,
    localparam int CNT_WIDTH = $clog2(LENGTH + 1)
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         out_ready,
    input  logic                         in_flush,
    output logic signed [DATA_WIDTH-1:0] out_addends [LENGTH],
    output logic        [CNT_WIDTH-1:0]  out_len,
    output logic                         out_valid,
    input  logic                         in_ready
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] LENGTH_CNT = CNT_WIDTH'(LENGTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    collector_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;
    logic [CNT_WIDTH-1:0]         len_q, len_d;
    logic signed [DATA_WIDTH-1:0] addends_q [LENGTH];

    logic                         accept;
    logic                         flush_close;
    logic [CNT_WIDTH-1:0]         zero_start;
    logic [LENGTH-1:0]            slot_we;
    logic [LENGTH-1:0]            slot_ze;

    // Gated by reset so upstream never sees a handshake while the block is held in reset.
    assign out_ready = (state_q == FILL) && !in_rst;
    assign out_valid = (state_q == HOLD);
    assign out_len   = len_q;
    assign out_addends = addends_q;
    assign accept    = in_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        flush_close = 1'b0;
        case (state_q)
            FILL: begin
                if (accept && count_q == LAST_IDX) begin
                    state_d = HOLD;
                    count_d = '0;
                    len_d   = LENGTH_CNT;
                end else if (in_flush && (accept || count_q != '0)) begin
                    state_d     = HOLD;
                    count_d     = '0;
                    len_d       = accept ? count_q + CNT_ONE : count_q;
                    flush_close = 1'b1;
                end else if (accept) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (in_ready) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Pad region starts after the word written this cycle, if any.
    always_comb begin
        zero_start = accept ? count_q + CNT_ONE : count_q;
        slot_we    = '0;
        slot_ze    = '0;
        for (int i = 0; i < LENGTH; i++) begin
            slot_we[i] = accept && (CNT_WIDTH'(i) == count_q);
            slot_ze[i] = flush_close && (CNT_WIDTH'(i) >= zero_start);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= FILL;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                addends_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                if (slot_we[i]) begin
                    addends_q[i] <= in_data;
                end else if (slot_ze[i]) begin
                    addends_q[i] <= '0;
                end
            end
        end
    end

endmodule
